// File: rtl/fp_norm_if.sv
// fp_norm_if: operand/result handshake bundle for fp_normalizer_seq.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that
// edge. The consumer may change ready freely.
interface fp_norm_if #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8,
  parameter int EXT_W = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [MAN_W+2+EXT_W-1:0] in_sig;
  logic [EXP_W-1:0]         in_exp;
  logic                     in_sign;
  logic                     out_valid;
  logic                     out_ready;
  logic [MAN_W-1:0]         out_frac;
  logic [EXP_W-1:0]         out_exp;
  logic                     out_sign;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output in_valid, in_sig, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_frac, out_exp, out_sign, overflow, underflow
  );

  modport slave (
    input  in_valid, in_sig, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_frac, out_exp, out_sign, overflow, underflow
  );
endinterface

// File: rtl/fp_normalizer_seq.sv
// fp_normalizer_seq: sequential floating-point normalize and round.
// It takes an unnormalized significand with a carry bit and a hidden bit. It
// shifts the significand one bit per cycle until the hidden bit is set, then
// rounds it and presents the packed result.
// Define ROUND_NEAREST_EVEN_EN to round to nearest with ties to even.
// Without it the extension bits are truncated. The ROUND cycle is present
// in both builds.
module fp_normalizer_seq #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8,
  parameter int EXT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_norm_if.slave   bus,
  output logic [1:0] state_o
);
  localparam int SIG_W = MAN_W + 2 + EXT_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_MAX = (EXP_W+1)'((1 << EXP_W) - 1);

  logic [1:0]       state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic             sign_q, sign_d;
  logic             out_valid_q, out_valid_d;
  logic [MAN_W-1:0] out_frac_q, out_frac_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic             out_sign_q, out_sign_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [MAN_W-1:0] frac_raw;
  logic             round_up;
  logic [MAN_W:0]   frac_sum;
  logic [EXP_W:0]   exp_rnd;
  logic [MAN_W-1:0] frac_rnd;
  logic             exp_ovf;

  // Rounding of the normalized significand held in sig_q (used in ROUND)
  always_comb begin
    frac_raw = sig_q[EXT_W +: MAN_W];
`ifdef ROUND_NEAREST_EVEN_EN
    // guard = top extension bit; sticky = OR of the rest; ties go to even
    round_up = sig_q[EXT_W-1] & ((|sig_q[EXT_W-2:0]) | frac_raw[0]);
`else
    round_up = 1'b0;
`endif
    frac_sum = {1'b0, frac_raw} + {{MAN_W{1'b0}}, round_up};
    // A carry out of the fraction leaves the fraction at zero and bumps the exponent
    exp_rnd  = exp_q + {{EXP_W{1'b0}}, frac_sum[MAN_W]};
    frac_rnd = frac_sum[MAN_W] ? '0 : frac_sum[MAN_W-1:0];
    exp_ovf  = (exp_rnd >= EXP_MAX);
  end

  // Next-state and datapath logic for the IDLE/NORM/ROUND/DONE sequencer
  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    out_frac_d  = out_frac_q;
    out_exp_d   = out_exp_q;
    out_sign_d  = out_sign_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sig_d   = bus.in_sig;
          exp_d   = {1'b0, bus.in_exp};
          sign_d  = bus.in_sign;
          state_d = NORM;
        end
      end
      NORM: begin
        if (sig_q[SIG_W-1]) begin
          // The bit shifted out is kept as sticky in the LSB
          sig_d   = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ROUND;
        end else if (sig_q[SIG_W-2]) begin
          state_d = ROUND;
        end else if (sig_q == '0) begin
          out_frac_d  = '0;
          out_exp_d   = '0;
          out_sign_d  = sign_q;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (exp_q <= EXP_ONE) begin
          // No exponent left to shift into: flush to signed zero
          out_frac_d  = '0;
          out_exp_d   = '0;
          out_sign_d  = sign_q;
          ovf_d       = 1'b0;
          unf_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          sig_d = sig_q << 1;
          exp_d = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        out_frac_d  = exp_ovf ? '0 : frac_rnd;
        out_exp_d   = exp_ovf ? '1 : exp_rnd[EXP_W-1:0];
        out_sign_d  = sign_q;
        ovf_d       = exp_ovf;
        unf_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sig_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_frac_q  <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      out_frac_q  <= out_frac_d;
      out_exp_q   <= out_exp_d;
      out_sign_q  <= out_sign_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.out_frac  = out_frac_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_fp_normalizer_seq.sv
// tb_fp_normalizer_seq: scoreboard bench for fp_normalizer_seq (23/8/3 format).
module tb_fp_normalizer_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_w;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {sign, exp, frac, overflow, underflow} and expected latency
  logic [33:0] exp_q[$];
  int          lat_q[$];

  fp_norm_if #(.MAN_W(23), .EXP_W(8), .EXT_W(3)) bus ();

  fp_normalizer_seq #(.MAN_W(23), .EXP_W(8), .EXT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state_w)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [33:0] pack_out();
    return {bus.out_sign, bus.out_exp, bus.out_frac, bus.overflow, bus.underflow};
  endfunction

  // Reference model: closed-form normalize via leading-one position
  function automatic logic [33:0] model(input logic [27:0] sig, input logic [7:0] e,
                                        input logic s, output int lat);
    int p, n, ee, fr;
    logic [27:0] m;
    p = -1;
    for (int i = 0; i < 28; i++) if (sig[i]) p = i;
    if (p < 0) begin
      lat = 2;
      return {s, 33'd0};
    end
    ee = int'(e);
    if (p == 27) begin
      m = (sig >> 1) | {27'd0, sig[0]};
      ee = ee + 1;
      lat = 3;
    end else begin
      n = 26 - p;
      if (n > 0 && ee < n + 1) begin
        lat = ((ee >= 1) ? ee - 1 : 0) + 2;
        return {s, 31'd0, 2'b01};
      end
      m = sig << n;
      ee = ee - n;
      lat = 3 + n;
    end
    fr = int'(m[25:3]);
`ifdef ROUND_NEAREST_EVEN_EN
    begin
      int ext;
      ext = int'(m[2:0]);
      if (ext > 4 || (ext == 4 && (fr % 2) == 1)) fr = fr + 1;
      if (fr == (1 << 23)) begin
        fr = 0;
        ee = ee + 1;
      end
    end
`endif
    if (ee >= 255) return {s, 8'hFF, 23'd0, 2'b10};
    return {s, 8'(ee), 23'(fr), 2'b00};
  endfunction

  // Driver: push expectation, send one operand, wait for and retire the result
  task automatic run_op(input logic [27:0] sig, input logic [7:0] e, input logic s, input int stall);
    int          lat_e, lat, guard;
    logic [33:0] got, snap;
    exp_q.push_back(model(sig, e, s, lat_e));
    lat_q.push_back(lat_e);
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_sig   = sig;
    bus.in_exp   = e;
    bus.in_sign  = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 200);
    got = pack_out();
    for (int i = 0; i < stall; i++) begin
      check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      snap = pack_out();
      check("hold_outputs", 64'(snap), 64'(got));
      check("hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("valid_dropped", 64'(bus.out_valid), 64'd0);
    check("latency", 64'(lat), 64'(lat_q.pop_front()));
    check("result", 64'(got), 64'(exp_q.pop_front()));
  endtask

  initial begin
    logic [27:0] rsig;
    int          p;
    logic        stray;

    bus.in_valid  = 1'b0;
    bus.in_sig    = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({pack_out(), bus.out_valid, bus.in_ready}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_state", 64'(state_w), 64'd0);

    // directed cases
    run_op(28'h8000000, 8'd127, 1'b0, 0);           // carry: exp 128, latency 3
    run_op(28'h0000008, 8'd100, 1'b0, 0);           // 23 left shifts, latency 26
    run_op(28'h4000000 | 28'h8 | 28'h4, 8'd127, 1'b0, 0); // tie, odd LSB
    run_op(28'h8000000, 8'd254, 1'b0, 0);           // overflow
    run_op(28'h0000001, 8'd5, 1'b1, 0);             // underflow, sign kept
    run_op(28'h0000000, 8'd77, 1'b1, 0);            // signed zero
    run_op(28'h7FFFFFC, 8'd100, 1'b0, 0);           // rounding carry-out
    run_op(28'h7FFFFFC, 8'd254, 1'b1, 0);           // carry-out into overflow
    run_op(28'h4000005, 8'd0, 1'b0, 0);             // already normal, exp 0
    run_op(28'h8000003, 8'd10, 1'b1, 0);            // right shift with sticky
    run_op(28'h2000000, 8'd1, 1'b0, 0);             // exp 1 needs a shift -> underflow
    run_op(28'h4000000, 8'd60, 1'b1, 5);            // held 5 cycles in DONE

    // random cases
    for (int t = 0; t < 40; t++) begin
      p = $urandom_range(0, 28);
      if (p == 28) rsig = '0;
      else rsig = (28'($urandom) & ((28'd1 << p) - 28'd1)) | (28'd1 << p);
      run_op(rsig, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // reset in the middle of NORM discards the operand
    @(negedge clk);
    bus.in_sig   = 28'h0000008;
    bus.in_exp   = 8'd100;
    bus.in_sign  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_state_norm", 64'(state_w), 64'd1);
    rst_n = 1'b0;
    #2;
    check("midrst_outputs", 64'({pack_out(), bus.out_valid, bus.in_ready}), 64'd0);
    check("midrst_state", 64'(state_w), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) stray = 1'b1;
    end
    check("no_stray_valid", 64'(stray), 64'd0);
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
